// File: rtl/stopwatch_pkg.sv
// Shared definitions for the BCD stopwatch/timer: state encoding, digit limit
// and the prescaler width helper.
package stopwatch_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_RUN  = RUN,
        ST_HOLD = HOLD,
        ST_DONE = DONE
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Number of bits needed to hold 0..value-1.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((64'd1 << w) < 64'(value)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the counter chain. carry flags the digit sitting at the
// boundary for the current direction (9 when counting up, 0 when counting
// down), so the next digit steps together with this one.
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic       enable,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] loadValue,
    output logic [3:0] digit,
    output logic       carry
);

    logic [3:0] r_digit;

    // Digit register: reset, saturating preload, then decimal step.
    // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_digit <= 4'd0;
        end else if (load) begin
            r_digit <= (loadValue > BCD_MAX) ? BCD_MAX : loadValue;
        end else if (enable) begin
            if (up) begin
                r_digit <= (r_digit >= BCD_MAX) ? 4'd0 : r_digit + 4'd1;
            end else begin
                r_digit <= (r_digit == 4'd0) ? BCD_MAX : r_digit - 4'd1;
            end
        end
    end

    assign carry = up ? (r_digit == BCD_MAX) : (r_digit == 4'd0);
    assign digit = r_digit;

endmodule

// File: rtl/stopwatch_timer.sv
// BCD stopwatch/countdown timer: prescaler, run/hold/done FSM, limit and
// wrap detection around a chain of bcd_digit instances.
module stopwatch_timer
    import stopwatch_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 524288,
    parameter int WRAP     = 0
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                start,
    input  logic                paused,
    input  logic                countUp,
    input  logic                clear,
    input  logic                load,
    input  logic [4*DIGITS-1:0] loadValue,
    output logic [4*DIGITS-1:0] Count,
    output logic                running,
    output logic                tick,
    output logic                expired
);

    localparam int             PW         = (clog2(TICK_DIV) < 1) ? 1 : clog2(TICK_DIV);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [PW-1:0]       r_presc;
    logic [PW-1:0]       w_presc_next;
    logic                r_tick;
    logic                r_expired;
    logic                r_running;
    logic                w_tick_next;
    logic                w_expired_next;
    logic                w_digit_en;
    logic                w_digit_load;
    logic [4*DIGITS-1:0] w_load_value;
    logic [DIGITS-1:0]   w_en;
    logic [DIGITS-1:0]   w_carry;
    logic                w_at_limit;
    logic                w_upper_bound;
    logic                w_near_limit;

    // Digit chain: each digit steps when all lower digits sit at their boundary.
    assign w_en[0]      = w_digit_en;
    assign w_digit_load = clear | load;
    assign w_load_value = clear ? '0 : loadValue;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        if (gi > 0) begin : g_chain
            assign w_en[gi] = w_en[gi-1] & w_carry[gi-1];
        end
        bcd_digit u_digit (
            .Clock     (Clock),
            .Reset     (Reset),
            .enable    (w_en[gi]),
            .up        (countUp),
            .load      (w_digit_load),
            .loadValue (w_load_value[4*gi +: 4]),
            .digit     (Count[4*gi +: 4]),
            .carry     (w_carry[gi])
        );
    end

    // Limit detection: at_limit is the current value being all-zero/all-nines;
    // near_limit is one step short of it, so the coming step lands on it.
    always_comb begin
        w_upper_bound = 1'b1;
        for (int i = 1; i < DIGITS; i++) begin
            w_upper_bound = w_upper_bound & w_carry[i];
        end
        w_at_limit   = &w_carry;
        w_near_limit = w_upper_bound && (Count[3:0] == (countUp ? 4'd8 : 4'd1));
    end

    // Next state, prescaler and step decision in priority order.
    // NOTE: every output of this block is given a default first so no latch is inferred.
    always_comb begin
        w_state_next   = r_state;
        w_presc_next   = r_presc;
        w_tick_next    = 1'b0;
        w_expired_next = 1'b0;
        w_digit_en     = 1'b0;
        if (clear || load) begin
            w_state_next = ST_IDLE;
            w_presc_next = '0;
        end else if (start && (r_state == ST_IDLE || r_state == ST_DONE)) begin
            w_state_next = ST_RUN;
            w_presc_next = '0;
        end else if (r_state == ST_RUN || r_state == ST_HOLD) begin
            if (paused) begin
                w_state_next = ST_HOLD;
            end else begin
                // Leaving HOLD also advances, so a pause of N cycles costs exactly N.
                w_state_next = ST_RUN;
                if (r_presc == PRESC_LAST) begin
                    w_presc_next = '0;
                    w_tick_next  = 1'b1;
                    if (WRAP != 0) begin
                        w_digit_en     = 1'b1;
                        w_expired_next = w_at_limit;
                    end else if (w_at_limit) begin
                        w_expired_next = 1'b1;
                        w_state_next   = ST_DONE;
                    end else begin
                        w_digit_en = 1'b1;
                        if (w_near_limit) begin
                            w_expired_next = 1'b1;
                            w_state_next   = ST_DONE;
                        end
                    end
                end else begin
                    w_presc_next = r_presc + PW'(1);
                end
            end
        end
    end

    // State, prescaler and registered status flags.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state   <= ST_IDLE;
            r_presc   <= '0;
            r_tick    <= 1'b0;
            r_expired <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_presc   <= w_presc_next;
            r_tick    <= w_tick_next;
            r_expired <= w_expired_next;
            r_running <= (w_state_next == ST_RUN) || (w_state_next == ST_HOLD);
        end
    end

    assign running = r_running;
    assign tick    = r_tick;
    assign expired = r_expired;

endmodule

// File: doc/stopwatch_timer.md
# stopwatch_timer

Parametrised BCD stopwatch/timer core. It divides `Clock` down to a counting tick and maintains a `DIGITS`-digit BCD count that runs up (stopwatch) or down (countdown timer). It supports pause, preload, clear and a selectable wrap or stop-at-limit mode. It feeds the seven-segment display driver directly, so no binary-to-BCD stage is needed downstream.

## Interface
Parameters:
- `DIGITS`, 4, number of BCD digits in `Count` (1–8).
- `TICK_DIV`, 524288, `Clock` cycles per count step (≥2).
- `WRAP`, 0, 0 = stop at limit and signal expiry; 1 = wrap around and keep running.

Ports:
- `Clock`  in  1  single clock domain; all logic on posedge.
- `Reset`  in  1  synchronous, active-high; dominates every other input.
- `start`  in  1  one-cycle pulse; enters RUN from IDLE or DONE.
- `paused`  in  1  level; while high in RUN/HOLD, prescaler and `Count` are frozen.
- `countUp`  in  1  direction: 1 = increment, 0 = decrement; sampled on each tick.
- `clear`  in  1  pulse; `Count` becomes 0, state becomes IDLE.
- `load`  in  1  pulse; `Count` becomes `loadValue`, state becomes IDLE.
- `loadValue`  in  4*DIGITS  BCD preload; any nibble >9 is loaded as 9.
- `Count`  out  4*DIGITS  BCD count; digit 0 is in bits [3:0].
- `running`  out  1  high in RUN and HOLD.
- `tick`  out  1  one-cycle pulse, coincident with each `Count` step.
- `expired`  out  1  one-cycle pulse on a limit hit (WRAP=0) or on a wrap (WRAP=1).

## Operation
- States:
  - IDLE: reset state; counting stopped.
  - RUN: prescaler advances.
  - HOLD: paused.
  - DONE: limit reached (WRAP=0 only).
- Transitions:
  - IDLE/DONE → RUN on `start`.
  - RUN → HOLD while `paused` is high.
  - HOLD → RUN when `paused` is low.
  - Any state → IDLE on `clear` or `load`.
  - RUN → DONE on a limit hit.
- Priority per edge: `Reset` > `clear` > `load` > `start` > `paused` > tick. A simultaneous `clear` and `start` leaves the block in IDLE.
- `start` while in RUN or HOLD is ignored.
- Prescaler:
  - Counts 0..TICK_DIV-1 in RUN only.
  - Zeroed on `start`, `clear`, `load` and `Reset`.
  - Holds its value in HOLD, so a pause does not lose partial intervals.
- Step: occurs on an edge where the prescaler equals TICK_DIV-1 in RUN. `Count` then moves ±1 in decimal, using per-digit carry/borrow.
- Limits, WRAP=0:
  - A down-count reaching all-zero goes to DONE.
  - An up-count reaching all-nines (10^DIGITS−1) goes to DONE.
  - `Count` holds the limit value, `expired` pulses, `running` drops.
  - In RUN already at the limit, the next step saturates, enters DONE and pulses `expired`.
- Limits, WRAP=1:
  - All-nines+1 → 0 and 0−1 → all-nines.
  - `expired` pulses on that step; state stays RUN.
- `countUp` may change at any time; only the value at a step edge matters.

## Timing
- Reset values: `Count` = 0, `running` = 0, `tick` = 0, `expired` = 0, state IDLE, prescaler 0.
- `start` sampled at edge E0: `running` is high after E0. The first `Count` change and `tick` occur after edge E0+TICK_DIV, then every TICK_DIV cycles.
- A `paused` high for N cycles delays subsequent steps by exactly N cycles.
- `Count`, `tick`, `expired` and `running` are all registered and update on the same edge. There is no combinational path from inputs to outputs.
- `clear`/`load`: the new `Count` is visible after the sampling edge; `tick` and `expired` are low in that cycle.
- `Reset` mid-run: all outputs return to reset values after that edge.

## Structure
- Shared package `stopwatch_pkg` holds:
  - State encoding localparams (IDLE=0, RUN=1, HOLD=2, DONE=3).
  - `BCD_MAX` = 9.
  - The prescaler width function clog2(TICK_DIV).
- Sub-module `bcd_digit`: one 4-bit digit with inputs enable, up, load, loadValue and output carry (carry on up-count, borrow on down-count). `stopwatch_timer` instantiates `DIGITS` of these in a carry chain.
- Top level holds the FSM, prescaler and `expired` detection.

## Test plan
Bench uses DIGITS=2, TICK_DIV=4.
- Reset, then `start` with `countUp`=1 → `Count` 00→01 four cycles after `start`, 02 after eight; `tick` pulses every 4 cycles.
- `load` 03, `countUp`=0, WRAP=0, `start` → steps 02, 01, 00; `expired` pulses once with the 00 step; `running`=0; `Count` stays 00 for 20 further cycles.
- WRAP=1, `load` 98, up-count, `start` → 99, then 00 with an `expired` pulse; `running` stays 1; next step is 01.
- `paused` high for 10 cycles starting 2 cycles into an interval → next `tick` arrives exactly 10 cycles later than unpaused; `Count` unchanged during HOLD.
- `clear` and `start` in the same cycle → IDLE, `Count`=00, `running`=0; `load` with `loadValue`=0xA5 → `Count`=95.
- `Reset` asserted mid-interval in RUN → next edge: `Count`=00 and all flags 0; a following `start` gives a full TICK_DIV interval before the first step.
